div_mae_monitor: RTL and testbench
==================================

# div_mae_monitor

Downstream error-metric stage for the 16/8 approximate array dividers. For each dividend/divisor pair it takes the approximate quotient and remainder, recomputes the exact result with an internal 8-iteration restoring divider, and accumulates mean-absolute-error statistics (error sums, maximum, mismatch and sample counts). Characterisation benches and the power/MAE evaluation flow read these counters after a sweep.

## Interface
Parameters:
- ACC_W, 32, width of sample, mismatch and error-sum accumulators (minimum 8).
- SKIP_W, 16, width of the skipped-sample counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset. Synchronous and active-high.
- clr  in  1  synchronous clear of all accumulators. Does not affect the FSM.
- in_valid  in  1  sample present.
- in_ready  out  1  block can accept a sample.
- n  in  16  dividend.
- d  in  8  divisor.
- q_apx  in  8  approximate quotient under test.
- r_apx  in  8  approximate remainder under test.
- res_valid  out  1  one-cycle pulse when a sample's result is posted.
- res_skip  out  1  qualifies res_valid: the sample was not evaluated.
- q_exact  out  8  exact quotient of the last evaluated sample.
- r_exact  out  8  exact remainder of the last evaluated sample.
- q_err  out  8  |q_exact − q_apx| of the last evaluated sample.
- r_err  out  8  |r_exact − r_apx| of the last evaluated sample.
- q_err_max  out  8  running maximum of q_err.
- q_err_sum  out  ACC_W  saturating sum of q_err.
- r_err_sum  out  ACC_W  saturating sum of r_err.
- err_cnt  out  ACC_W  saturating count of samples with q_err≠0 or r_err≠0.
- sample_cnt  out  ACC_W  saturating count of evaluated samples.
- skip_cnt  out  SKIP_W  saturating count of skipped samples.

## Operation
- Handshake: a sample is accepted on an edge where in_valid and in_ready are both 1. On acceptance, n, d, q_apx and r_apx are captured internally. Inputs are ignored at all other times.
- Skip rule: a sample is skipped when d == 0 or when n[15:8] >= d, because the quotient does not fit in 8 bits. Skipped samples are counted only in skip_cnt.
- The FSM has three states:
  - IDLE: in_ready = 1.
    - Accepted skip sample: stay in IDLE, increment skip_cnt, pulse res_valid with res_skip = 1 on the next cycle.
    - Accepted valid sample: go to DIV.
  - DIV: 8 cycles with in_ready = 0. Restoring division runs with a 9-bit partial remainder initialised to n[15:8]. For i = 7 down to 0, one step per cycle:
    - rem = {rem[7:0], n[i]}.
    - If rem >= d: rem = rem − d and q[i] = 1; otherwise q[i] = 0.
    - After the 8th step, go to CMP.
  - CMP: 1 cycle with in_ready = 0.
    - Register q_exact, r_exact, q_err and r_err, using 8-bit absolute differences.
    - Update the accumulators: sample_cnt += 1; q_err_sum += q_err; r_err_sum += r_err; err_cnt += 1 if either error is nonzero; q_err_max = max(q_err_max, q_err).
    - Go to IDLE.
    - res_valid = 1 and res_skip = 0 in the following cycle.
- Saturation: every accumulator sticks at its all-ones value and never wraps.
- clr has priority. In a cycle where clr = 1, all accumulators and q_err_max clear to 0. Any concurrent update (CMP or skip) is dropped from the accumulators, but res_valid and the per-sample outputs still post normally.
- Per-sample outputs (q_exact, r_exact, q_err, r_err) hold until the next evaluated sample and are unaffected by skips and clr.

## Timing
- Reset: while rst = 1 every output is 0, including in_ready, and the state is IDLE. in_ready = 1 in the first cycle after rst deasserts.
- Evaluated sample: accepted at edge E0. DIV occupies the cycles following E0, E1..E8. CMP registers results at E9. res_valid is high in the cycle after E9 and updated counters are visible in that same cycle. in_ready returns to 1 in that same cycle.
  - Throughput: one evaluated sample per 10 cycles.
- Skipped sample: res_valid and the updated skip_cnt appear the cycle after acceptance. in_ready stays 1, so back-to-back skips are accepted every cycle.
- rst asserted mid-DIV or mid-CMP aborts the sample, clears everything, and posts no res_valid.
- in_valid held high while in_ready = 0 is not accepted. The source must hold its data until acceptance.

## Test plan
- n=100, d=7, q_apx=14, r_apx=2 -> exact q=14, r=2; q_err=0, r_err=0; sample_cnt=1, err_cnt=0; res_valid 10 cycles after acceptance.
- n=100, d=7, q_apx=12, r_apx=16 -> q_err=2, r_err=14; q_err_sum=2, r_err_sum=14, err_cnt=1, q_err_max=2.
- d=0, then n=0x0800 with d=8, then n=0x07FF with d=8 -> first two give res_skip=1 on consecutive cycles (skip_cnt=2). Third is evaluated: q=0xFF, r=7.
- ACC_W=8; feed 130 samples each with q_err=2 -> q_err_sum saturates at 255; sample_cnt=130.
- clr asserted in the CMP cycle of a sample with q_err=5 -> accumulators read 0 afterwards, res_valid still pulses, q_err output = 5.
- rst pulsed at DIV cycle 4 -> no res_valid; all outputs 0; in_ready=1 one cycle after rst drops; the next sample evaluates correctly.

Source files
------------

// File: rtl/div_mae_monitor.sv
// Error-metric stage for 16/8 approximate dividers: recomputes the exact quotient/remainder
// with an 8-step restoring divider and accumulates saturating MAE statistics.
//   state | meaning
//   IDLE  | ready for a sample; skip samples are posted straight from here
//   DIV   | one restoring-division step per cycle, 8 cycles
//   CMP   | register exact results and errors, update accumulators
module div_mae_monitor #(
    parameter int ACC_W  = 32,
    parameter int SKIP_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       n,
    input  logic [7:0]        d,
    input  logic [7:0]        q_apx,
    input  logic [7:0]        r_apx,
    output logic              res_valid,
    output logic              res_skip,
    output logic [7:0]        q_exact,
    output logic [7:0]        r_exact,
    output logic [7:0]        q_err,
    output logic [7:0]        r_err,
    output logic [7:0]        q_err_max,
    output logic [ACC_W-1:0]  q_err_sum,
    output logic [ACC_W-1:0]  r_err_sum,
    output logic [ACC_W-1:0]  err_cnt,
    output logic [ACC_W-1:0]  sample_cnt,
    output logic [SKIP_W-1:0] skip_cnt
);

    typedef enum logic [1:0] {IDLE, DIV, CMP} state_t;

    state_t      state, state_nxt;
    logic [7:0]  n_lo, d_r, qa_r, ra_r, q_acc;
    logic [8:0]  rem, rem_sh, rem_nxt;
    logic [2:0]  cnt;
    logic        accept, skip, q_bit;
    logic [7:0]  q_err_nxt, r_err_nxt;

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a, input logic [7:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {{(ACC_W-7){1'b0}}, b};
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
    endfunction

    assign accept = in_valid && in_ready;
    // Quotient fits in 8 bits only when the upper dividend byte is below the divisor
    assign skip   = (d == 8'd0) || (n[15:8] >= d);

    assign rem_sh  = {rem[7:0], n_lo[cnt]};
    assign q_bit   = (rem_sh >= {1'b0, d_r});
    assign rem_nxt = q_bit ? (rem_sh - {1'b0, d_r}) : rem_sh;

    assign q_err_nxt = (q_acc >= qa_r) ? (q_acc - qa_r) : (qa_r - q_acc);
    assign r_err_nxt = (rem[7:0] >= ra_r) ? (rem[7:0] - ra_r) : (ra_r - rem[7:0]);

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (accept && !skip) state_nxt = DIV;
            end
            DIV:     if (cnt == 3'd0) state_nxt = CMP;
            CMP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            n_lo       <= '0;
            d_r        <= '0;
            qa_r       <= '0;
            ra_r       <= '0;
            q_acc      <= '0;
            rem        <= '0;
            cnt        <= '0;
            res_valid  <= 1'b0;
            res_skip   <= 1'b0;
            q_exact    <= '0;
            r_exact    <= '0;
            q_err      <= '0;
            r_err      <= '0;
            q_err_max  <= '0;
            q_err_sum  <= '0;
            r_err_sum  <= '0;
            err_cnt    <= '0;
            sample_cnt <= '0;
            skip_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            res_valid <= 1'b0;
            res_skip  <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (skip) begin
                        res_valid <= 1'b1;
                        res_skip  <= 1'b1;
                        if (skip_cnt != {SKIP_W{1'b1}}) skip_cnt <= skip_cnt + 1'b1;
                    end else begin
                        n_lo  <= n[7:0];
                        d_r   <= d;
                        qa_r  <= q_apx;
                        ra_r  <= r_apx;
                        rem   <= {1'b0, n[15:8]};
                        q_acc <= '0;
                        cnt   <= 3'd7;
                    end
                end
                DIV: begin
                    rem   <= rem_nxt;
                    q_acc <= {q_acc[6:0], q_bit};
                    cnt   <= cnt - 3'd1;
                end
                CMP: begin
                    q_exact    <= q_acc;
                    r_exact    <= rem[7:0];
                    q_err      <= q_err_nxt;
                    r_err      <= r_err_nxt;
                    res_valid  <= 1'b1;
                    sample_cnt <= sat_add(sample_cnt, 8'd1);
                    q_err_sum  <= sat_add(q_err_sum, q_err_nxt);
                    r_err_sum  <= sat_add(r_err_sum, r_err_nxt);
                    if ((q_err_nxt != 8'd0) || (r_err_nxt != 8'd0)) err_cnt <= sat_add(err_cnt, 8'd1);
                    if (q_err_nxt > q_err_max) q_err_max <= q_err_nxt;
                end
                default: ;
            endcase
            // Clear wins over any same-cycle accumulator update
            if (clr) begin
                q_err_max  <= '0;
                q_err_sum  <= '0;
                r_err_sum  <= '0;
                err_cnt    <= '0;
                sample_cnt <= '0;
                skip_cnt   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_div_mae_monitor.sv
// Directed bench for div_mae_monitor (ACC_W=8 so accumulator saturation is reachable).
module tb_div_mae_monitor;

    localparam int ACC_W  = 8;
    localparam int SKIP_W = 16;

    logic              clk = 1'b0;
    logic              rst, clr, in_valid;
    logic              in_ready, res_valid, res_skip;
    logic [15:0]       n;
    logic [7:0]        d, q_apx, r_apx;
    logic [7:0]        q_exact, r_exact, q_err, r_err, q_err_max;
    logic [ACC_W-1:0]  q_err_sum, r_err_sum, err_cnt, sample_cnt;
    logic [SKIP_W-1:0] skip_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int lat;
    int pulses;
    logic skp;

    always #5 clk = ~clk;

    div_mae_monitor #(.ACC_W(ACC_W), .SKIP_W(SKIP_W)) dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .n(n), .d(d), .q_apx(q_apx), .r_apx(r_apx),
        .res_valid(res_valid), .res_skip(res_skip),
        .q_exact(q_exact), .r_exact(r_exact), .q_err(q_err), .r_err(r_err),
        .q_err_max(q_err_max), .q_err_sum(q_err_sum), .r_err_sum(r_err_sum),
        .err_cnt(err_cnt), .sample_cnt(sample_cnt), .skip_cnt(skip_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Present one sample while idle and wait (bounded) for its result pulse
    task automatic run_sample(input logic [15:0] nn, input logic [7:0] dd, input logic [7:0] qa,
                              input logic [7:0] ra, output int l, output logic s);
        @(negedge clk);
        in_valid = 1'b1; n = nn; d = dd; q_apx = qa; r_apx = ra;
        @(posedge clk);
        #1 in_valid = 1'b0;
        l = 0;
        s = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (res_valid) begin
                l = i;
                s = res_skip;
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; n = '0; d = '0; q_apx = '0; r_apx = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_sample_cnt", sample_cnt, 0);
        chk("rst_q_exact", q_exact, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        // exact approximation
        run_sample(16'd100, 8'd7, 8'd14, 8'd2, lat, skp);
        chk("t1_latency", lat, 10);
        chk("t1_skip", skp, 0);
        chk("t1_q_exact", q_exact, 14);
        chk("t1_r_exact", r_exact, 2);
        chk("t1_q_err", q_err, 0);
        chk("t1_r_err", r_err, 0);
        chk("t1_sample_cnt", sample_cnt, 1);
        chk("t1_err_cnt", err_cnt, 0);
        chk("t1_in_ready", in_ready, 1);

        // erroneous approximation
        run_sample(16'd100, 8'd7, 8'd12, 8'd16, lat, skp);
        chk("t2_latency", lat, 10);
        chk("t2_q_err", q_err, 2);
        chk("t2_r_err", r_err, 14);
        chk("t2_q_err_sum", q_err_sum, 2);
        chk("t2_r_err_sum", r_err_sum, 14);
        chk("t2_err_cnt", err_cnt, 1);
        chk("t2_q_err_max", q_err_max, 2);
        chk("t2_sample_cnt", sample_cnt, 2);

        // back-to-back skips: d=0, then n[15:8]==d
        @(negedge clk);
        in_valid = 1'b1; n = 16'd500; d = 8'd0; q_apx = 8'd1; r_apx = 8'd1;
        @(posedge clk);
        #1 n = 16'h0800; d = 8'd8;
        @(negedge clk);
        chk("skip1_valid", res_valid, 1);
        chk("skip1_flag", res_skip, 1);
        chk("skip1_cnt", skip_cnt, 1);
        chk("skip1_in_ready", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("skip2_valid", res_valid, 1);
        chk("skip2_flag", res_skip, 1);
        chk("skip2_cnt", skip_cnt, 2);
        chk("skip_q_exact_held", q_exact, 14);
        chk("skip_sample_cnt", sample_cnt, 2);

        run_sample(16'h07FF, 8'd8, 8'hFF, 8'd7, lat, skp);
        chk("t3_latency", lat, 10);
        chk("t3_skip", skp, 0);
        chk("t3_q_exact", q_exact, 255);
        chk("t3_r_exact", r_exact, 7);
        chk("t3_sample_cnt", sample_cnt, 3);
        chk("t3_err_cnt", err_cnt, 1);

        // clr during the CMP cycle of a sample with q_err=5
        @(negedge clk);
        in_valid = 1'b1; n = 16'd100; d = 8'd7; q_apx = 8'd9; r_apx = 8'd2;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        chk("clr_res_valid", res_valid, 1);
        chk("clr_q_err", q_err, 5);
        chk("clr_q_err_sum", q_err_sum, 0);
        chk("clr_sample_cnt", sample_cnt, 0);
        chk("clr_err_cnt", err_cnt, 0);
        chk("clr_q_err_max", q_err_max, 0);
        chk("clr_skip_cnt", skip_cnt, 0);

        // rst in the middle of DIV aborts the sample
        @(negedge clk);
        in_valid = 1'b1; n = 16'd100; d = 8'd7; q_apx = 8'd9; r_apx = 8'd2;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready_after", in_ready, 1);
        chk("midrst_q_err", q_err, 0);
        chk("midrst_q_exact", q_exact, 0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (res_valid) pulses++;
        end
        chk("midrst_no_res_valid", pulses, 0);
        run_sample(16'd1000, 8'd9, 8'd111, 8'd3, lat, skp);
        chk("midrst_next_latency", lat, 10);
        chk("midrst_next_q_exact", q_exact, 111);
        chk("midrst_next_r_exact", r_exact, 1);
        chk("midrst_next_r_err", r_err, 2);
        chk("midrst_next_sample_cnt", sample_cnt, 1);

        // saturation with 8-bit accumulators
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        for (int i = 1; i <= 130; i++) begin
            run_sample(16'd100, 8'd7, 8'd16, 8'd2, lat, skp);
            if (i == 127) chk("sat_q_err_sum_127", q_err_sum, 254);
            if (i == 128) chk("sat_q_err_sum_128", q_err_sum, 255);
        end
        chk("sat_q_err_sum", q_err_sum, 255);
        chk("sat_sample_cnt", sample_cnt, 130);
        chk("sat_err_cnt", err_cnt, 130);
        chk("sat_r_err_sum", r_err_sum, 0);
        chk("sat_q_err_max", q_err_max, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
